output_scanout: RTL and testbench

Frame read-out stage directly downstream of the alpha blender. When started, it reads the blended output buffer from shared SRAM one 64-word block at a time. It then serialises each block into a stream of 24-bit pixels with a valid/ready handshake for the display/host side, and pulses done after the last pixel of the frame is accepted. It shares the SRAM port arbitration scheme of the other GPU stages and only drives the bus while busy.

---
 rtl/output_scanout.sv | 103 ++++++++++
 tb/tb_output_scanout.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_scanout.sv
// rtl/output_scanout.sv - frame read-out: SRAM block reads serialised into a 24-bit pixel stream
module output_scanout #(
   parameter int ADDR_SIZE_BITS  = 24,
   parameter int WORD_SIZE_BYTES = 3,
   parameter int DATA_SIZE_WORDS = 64,
   parameter int BASE_ADDR       = 143360,
   parameter int NUM_WORDS       = 65536
) (
   input  logic                                         clk,
   input  logic                                         n_rst,
   input  logic                                         out_en,
   output logic                                         busy,
   output logic                                         out_done,
   output logic                                         read_enable,
   output logic [ADDR_SIZE_BITS-1:0]                    address,
   input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
   output logic [WORD_SIZE_BYTES*8-1:0]                 pix_data,
   output logic                                         pix_valid,
   input  logic                                         pix_ready,
   output logic                                         pix_last
);
   localparam int PW = WORD_SIZE_BYTES * 8;
   localparam int LW = PW * DATA_SIZE_WORDS;
   localparam int IW = $clog2(DATA_SIZE_WORDS);
   localparam logic [ADDR_SIZE_BITS-1:0] BASE     = ADDR_SIZE_BITS'(BASE_ADDR);
   localparam logic [ADDR_SIZE_BITS-1:0] STEP     = ADDR_SIZE_BITS'(DATA_SIZE_WORDS);
   localparam logic [ADDR_SIZE_BITS-1:0] LAST_OFF = ADDR_SIZE_BITS'(NUM_WORDS - DATA_SIZE_WORDS);
   localparam logic [IW-1:0]             LAST_IDX = IW'(DATA_SIZE_WORDS - 1);

   typedef enum logic [2:0] {IDLE, READ, CAPTURE, STREAM, DONE} state_t;

   state_t                    state;
   logic [ADDR_SIZE_BITS-1:0] off;
   logic [IW-1:0]             idx;
   logic [LW-1:0]             line;

   // Outputs are registered alongside the transition so read_enable is high in the cycle after out_en is sampled.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         off         <= '0;
         idx         <= '0;
         line        <= '0;
         busy        <= 1'b0;
         out_done    <= 1'b0;
         read_enable <= 1'b0;
         address     <= '0;
         pix_valid   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               off <= '0;
               if (out_en) begin
                  state       <= READ;
                  busy        <= 1'b1;
                  read_enable <= 1'b1;
                  address     <= BASE;
               end
            end
            READ: begin
               read_enable <= 1'b0;
               address     <= '0;
               state       <= CAPTURE;
            end
            CAPTURE: begin
               line      <= read_data;
               idx       <= '0;
               pix_valid <= 1'b1;
               state     <= STREAM;
            end
            STREAM: begin
               if (pix_ready) begin
                  if (idx != LAST_IDX) begin
                     idx <= idx + 1'b1;
                  end else begin
                     pix_valid <= 1'b0;
                     if (off == LAST_OFF) begin
                        out_done <= 1'b1;
                        state    <= DONE;
                     end else begin
                        off         <= off + STEP;
                        read_enable <= 1'b1;
                        address     <= BASE + off + STEP;
                        state       <= READ;
                     end
                  end
               end
            end
            DONE: begin
               out_done <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The line register keeps stale data after a frame; gate it so pix_data reads 0 whenever not valid.
   assign pix_data = pix_valid ? line[idx*PW +: PW] : '0;
   assign pix_last = pix_valid && (idx == LAST_IDX) && (off == LAST_OFF);

endmodule

// File: tb/tb_output_scanout.sv
// tb/tb_output_scanout.sv - randomized self-checking bench for output_scanout
module tb_output_scanout;
   localparam int BASE = 143360;
   localparam int DW   = 64;
   localparam int NW_S = 128;
   localparam int NW_B = 65536;
   localparam int BW   = 24 * DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Small-frame instance
   logic          n_rst = 1'b1, out_en = 1'b0, pix_ready = 1'b1;
   logic          busy, out_done, read_enable, pix_valid, pix_last;
   logic [23:0]   address, pix_data;
   logic [BW-1:0] read_data = '0;

   output_scanout #(.NUM_WORDS(NW_S)) dut (
      .clk(clk), .n_rst(n_rst), .out_en(out_en), .busy(busy), .out_done(out_done),
      .read_enable(read_enable), .address(address), .read_data(read_data),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last)
   );

   // Default-parameter instance
   logic          n_rst_b = 1'b1, out_en_b = 1'b0, pix_ready_b = 1'b1;
   logic          busy_b, out_done_b, read_enable_b, pix_valid_b, pix_last_b;
   logic [23:0]   address_b, pix_data_b;
   logic [BW-1:0] read_data_b = '0;

   output_scanout dut_b (
      .clk(clk), .n_rst(n_rst_b), .out_en(out_en_b), .busy(busy_b), .out_done(out_done_b),
      .read_enable(read_enable_b), .address(address_b), .read_data(read_data_b),
      .pix_data(pix_data_b), .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .pix_last(pix_last_b)
   );

   // SRAM models: block data appears in the cycle after the strobe
   logic [23:0] mem [NW_S];
   logic [23:0] woff;
   always @(posedge clk) begin
      if (read_enable) begin
         for (int j = 0; j < DW; j++) begin
            woff = address - 24'(BASE) + 24'(j);
            read_data[j*24 +: 24] <= mem[woff[6:0]];
         end
      end
      if (read_enable_b) begin
         for (int j = 0; j < DW; j++) read_data_b[j*24 +: 24] <= address_b - 24'(BASE) + 24'(j);
      end
   end

   bit rand_ready = 1'b0;
   initial forever begin
      @(posedge clk); #1;
      pix_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
   end

   // Monitor of the small instance
   logic [23:0] got_q[$];
   bit          last_q[$];
   int          hs_cyc_q[$], addr_q[$], rd_cyc_q[$], done_q[$];
   int          stab_err = 0, addr_err = 0;
   logic        hold_p = 1'b0, hold_l = 1'b0;
   logic [23:0] hold_d = '0;
   initial forever begin
      @(negedge clk);
      if (hold_p && !(pix_valid && pix_data == hold_d && pix_last == hold_l)) stab_err++;
      hold_p = pix_valid && !pix_ready;
      hold_d = pix_data;
      hold_l = pix_last;
      if (pix_valid && pix_ready) begin
         got_q.push_back(pix_data);
         last_q.push_back(pix_last);
         hs_cyc_q.push_back(cyc);
      end
      if (read_enable) begin
         addr_q.push_back(int'(address));
         rd_cyc_q.push_back(cyc);
      end else if (address != 0) addr_err++;
      if (out_done) done_q.push_back(cyc);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_mon();
      got_q.delete(); last_q.delete(); hs_cyc_q.delete();
      addr_q.delete(); rd_cyc_q.delete(); done_q.delete();
   endtask

   task automatic start_frame();
      out_en = 1'b1;
      tick();
      out_en = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int n, input int budget);
      int seen = 0, t = 0;
      while (seen < n && t < budget) begin
         @(negedge clk);
         if (out_done) seen++;
         t++;
      end
      check({tag, "_done_seen"}, seen, n);
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < NW_S; i++) mem[i] = 24'($urandom);
   endtask

   task automatic check_frame(input string tag, input int frames);
      int mism = 0, nlast = 0, lastpos = -1;
      check({tag, "_count"}, got_q.size(), frames * NW_S);
      for (int i = 0; i < got_q.size(); i++) begin
         if (got_q[i] !== mem[i % NW_S]) mism++;
         if (last_q[i]) begin
            nlast++;
            lastpos = i;
         end
      end
      check({tag, "_data_mismatches"}, mism, 0);
      check({tag, "_last_count"}, nlast, frames);
      check({tag, "_last_pos"}, lastpos, frames * NW_S - 1);
   endtask

   bit big_finished = 1'b0;

   // Full default-size frame, running alongside the small-instance tests
   initial begin
      int hs = 0, bad = 0, first_rd = -1, last_addr = 0, done_cyc = 0, t = 0;
      bit fin = 1'b0;
      #1 n_rst_b = 1'b0;
      repeat (3) @(posedge clk);
      #1 n_rst_b = 1'b1;
      @(posedge clk); #1 out_en_b = 1'b1;
      @(posedge clk); #1 out_en_b = 1'b0;
      while (!fin && t < 70000) begin
         @(negedge clk);
         t++;
         if (read_enable_b) begin
            if (first_rd < 0) first_rd = cyc;
            last_addr = int'(address_b);
         end
         if (pix_valid_b) begin
            if (pix_data_b != 24'(hs)) bad++;
            if (pix_last_b != (hs == NW_B - 1)) bad++;
            hs++;
         end
         if (out_done_b) begin
            fin = 1'b1;
            done_cyc = cyc;
         end
      end
      check("big_finished", fin, 1);
      check("big_pixels", hs, NW_B);
      check("big_pixel_errors", bad, 0);
      check("big_last_read_addr", last_addr, BASE + NW_B - DW);
      check("big_latency", done_cyc - first_rd, (NW_B / DW) * (DW + 2));
      big_finished = 1'b1;
   end

   initial begin
      int extra, t, hs;
      // Reset holds everything at zero even with out_en high
      out_en = 1'b1;
      #1 n_rst = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_out_done", out_done, 0);
      check("rst_read_enable", read_enable, 0);
      check("rst_address", address, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_pix_data", pix_data, 0);
      check("rst_pix_last", pix_last, 0);
      tick();
      out_en = 1'b0;
      n_rst = 1'b1;
      repeat (2) tick();
      check("idle_after_release", busy, 0);

      // Identity frame, ready held high
      for (int i = 0; i < NW_S; i++) mem[i] = 24'(i);
      clear_mon();
      start_frame();
      @(negedge clk);
      check("start_read_enable", read_enable, 1);
      check("start_address", address, BASE);
      @(negedge clk);
      check("capture_no_valid", pix_valid, 0);
      @(negedge clk);
      check("first_valid", pix_valid, 1);
      wait_done("ident", 1, 2000);
      @(negedge clk);
      check("busy_after_done", busy, 0);
      tick();
      check_frame("ident", 1);
      check("ident_reads", addr_q.size(), NW_S / DW);
      check("ident_addr0", addr_q[0], BASE);
      check("ident_addr1", addr_q[1], BASE + DW);
      check("ident_done_after_last", done_q[0] - hs_cyc_q[hs_cyc_q.size()-1], 1);
      check("ident_latency", done_q[0] - rd_cyc_q[0], (NW_S / DW) * (DW + 2));

      // Random backpressure, with an ignored start request mid-frame
      randomize_mem();
      clear_mon();
      rand_ready = 1'b1;
      start_frame();
      repeat (100) tick();
      start_frame();
      wait_done("bp", 1, 3000);
      extra = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_done) extra++;
      end
      check("bp_extra_done", extra, 0);
      check("bp_idle", busy, 0);
      rand_ready = 1'b0;
      tick();
      check_frame("bp", 1);
      check("bp_stable_errors", stab_err, 0);
      check("bp_reads", addr_q.size(), NW_S / DW);

      // out_en held high: back-to-back frames
      randomize_mem();
      clear_mon();
      out_en = 1'b1;
      wait_done("b2b", 2, 1000);
      out_en = 1'b0;
      repeat (5) tick();
      check_frame("b2b", 2);
      check("b2b_reads", addr_q.size(), 2 * NW_S / DW);
      check("b2b_addr2", addr_q[2], BASE);
      check("b2b_addr3", addr_q[3], BASE + DW);
      check("b2b_done_gap", done_q[1] - done_q[0], (NW_S / DW) * (DW + 2) + 2);
      check("b2b_idle", busy, 0);

      // Reset with pixel 70 on the bus
      randomize_mem();
      clear_mon();
      start_frame();
      hs = 0;
      t = 0;
      while (hs < 70 && t < 1000) begin
         @(negedge clk);
         if (pix_valid && pix_ready) hs++;
         t++;
      end
      check("mid_reached_70", hs, 70);
      @(posedge clk); #2;
      check("mid_pixel70", pix_data, mem[70]);
      n_rst = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_pix_valid", pix_valid, 0);
      check("mid_rst_pix_data", pix_data, 0);
      check("mid_rst_pix_last", pix_last, 0);
      check("mid_rst_read_enable", read_enable, 0);
      check("mid_rst_address", address, 0);
      repeat (2) tick();
      n_rst = 1'b1;
      repeat (5) tick();
      check("mid_stays_idle", busy, 0);
      clear_mon();
      start_frame();
      wait_done("restart", 1, 2000);
      tick();
      check_frame("restart", 1);
      check("restart_addr0", addr_q[0], BASE);

      t = 0;
      while (!big_finished && t < 80000) begin
         @(negedge clk);
         t++;
      end
      check("big_instance_completed", big_finished, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
